perceptron_branch_predictor: RTL and testbench



---
 rtl/perceptron_branch_predictor.sv | 202 ++++++++++++++++++++
 tb/tb_perceptron_branch_predictor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_branch_predictor
// Description : Clocked perceptron conditional-branch predictor with a
//               registered predict path, speculative GHR with mispredict
//               repair, and a 3-cycle threshold-gated training FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_branch_predictor #(
    parameter int PC_W     = 32,
    parameter int HIST_LEN = 8,
    parameter int WEIGHT_W = 8,
    parameter int ENTRIES  = 256,
    parameter int THETA    = 29,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int SUM_W   = WEIGHT_W + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_predValid,
    input  logic [PC_W-1:0]         i_predPc_32,
    output logic                    o_predValid,
    output logic                    o_predTaken,
    output logic signed [SUM_W-1:0] o_predSum,
    output logic [HIST_LEN-1:0]     o_predHist,
    input  logic                    i_updValid,
    output logic                    o_updReady,
    input  logic [PC_W-1:0]         i_updPc_32,
    input  logic [HIST_LEN-1:0]     i_updHist,
    input  logic signed [SUM_W-1:0] i_updSum,
    input  logic                    i_updTaken,
    input  logic                    i_updMispredict,
    output logic [15:0]             o_trainCnt_16,
    output logic [15:0]             o_mispredCnt_16
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic signed [WEIGHT_W-1:0] c_w_max = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] c_w_min = -c_w_max;
    localparam logic signed [SUM_W:0]      c_theta = (SUM_W+1)'(THETA);

    // Weight table: bias plus one weight per history bit, all flops so reset clears it.
    logic signed [WEIGHT_W-1:0] r_bias [ENTRIES];
    logic signed [WEIGHT_W-1:0] r_wt   [ENTRIES][HIST_LEN];

    logic [HIST_LEN-1:0]        r_ghr;
    state_t                     r_state;
    logic                       r_upd_ready;
    logic [15:0]                r_train_cnt;
    logic [15:0]                r_mispred_cnt;

    logic                       r_pred_valid;
    logic                       r_pred_taken;
    logic signed [SUM_W-1:0]    r_pred_sum;
    logic [HIST_LEN-1:0]        r_pred_hist;

    // Working copy of the row being trained.
    logic [IDX_W-1:0]           r_idx;
    logic [HIST_LEN-1:0]        r_hist;
    logic                       r_t;
    logic signed [WEIGHT_W-1:0] r_row_b;
    logic signed [WEIGHT_W-1:0] r_row_w [HIST_LEN];

    logic [IDX_W-1:0]           w_pred_idx;
    logic [IDX_W-1:0]           w_upd_idx;
    logic signed [SUM_W-1:0]    w_pred_sum;
    logic                       w_pred_taken;
    logic signed [SUM_W:0]      w_sum_ext;
    logic signed [SUM_W:0]      w_upd_mag;
    logic                       w_upd_accept;
    logic                       w_train;
    logic                       w_unused_pc;

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] v);
        return {{(SUM_W-WEIGHT_W){v[WEIGHT_W-1]}}, v};
    endfunction

    // Step a weight by +/-1, clamping symmetrically so the most-negative code never appears.
    function automatic logic signed [WEIGHT_W-1:0] sat_step(
        input logic signed [WEIGHT_W-1:0] v,
        input logic                       up
    );
        if (up)
            return (v >= c_w_max) ? c_w_max : v + WEIGHT_W'(1);
        else
            return (v <= c_w_min) ? c_w_min : v - WEIGHT_W'(1);
    endfunction

    assign w_pred_idx = i_predPc_32[2 +: IDX_W];
    assign w_upd_idx  = i_updPc_32[2 +: IDX_W];
    assign w_unused_pc = ^{i_predPc_32[1:0], i_predPc_32[PC_W-1:IDX_W+2],
                           i_updPc_32[1:0],  i_updPc_32[PC_W-1:IDX_W+2]};

    always_comb begin
        w_pred_sum = sext(r_bias[w_pred_idx]);
        for (int i = 0; i < HIST_LEN; i++) begin
            if (r_ghr[i])
                w_pred_sum = w_pred_sum + sext(r_wt[w_pred_idx][i]);
            else
                w_pred_sum = w_pred_sum - sext(r_wt[w_pred_idx][i]);
        end
    end

    assign w_pred_taken = ~w_pred_sum[SUM_W-1];

    // One extra bit so the magnitude of the most-negative sum is representable.
    assign w_sum_ext    = {i_updSum[SUM_W-1], i_updSum};
    assign w_upd_mag    = w_sum_ext[SUM_W] ? -w_sum_ext : w_sum_ext;
    assign w_upd_accept = i_updValid && r_upd_ready;
    assign w_train      = i_updMispredict || (w_upd_mag <= c_theta);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_bias[e] <= '0;
                for (int i = 0; i < HIST_LEN; i++)
                    r_wt[e][i] <= '0;
            end
            r_ghr         <= '0;
            r_state       <= S_IDLE;
            r_upd_ready   <= 1'b1;
            r_train_cnt   <= '0;
            r_mispred_cnt <= '0;
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_sum    <= '0;
            r_pred_hist   <= '0;
            r_idx         <= '0;
            r_hist        <= '0;
            r_t           <= 1'b0;
            r_row_b       <= '0;
            for (int i = 0; i < HIST_LEN; i++)
                r_row_w[i] <= '0;
        end else begin
            r_pred_valid <= i_predValid;
            if (i_predValid) begin
                r_pred_sum   <= w_pred_sum;
                r_pred_taken <= w_pred_taken;
                r_pred_hist  <= r_ghr;
            end

            // Repair wins over the speculative shift; the prediction above still used the old GHR.
            if (w_upd_accept && i_updMispredict) begin
                r_ghr <= {i_updHist[HIST_LEN-2:0], i_updTaken};
                if (r_mispred_cnt != 16'hFFFF)
                    r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end else if (i_predValid) begin
                r_ghr <= {r_ghr[HIST_LEN-2:0], w_pred_taken};
            end

            case (r_state)
                S_IDLE: begin
                    if (w_upd_accept && w_train) begin
                        r_idx   <= w_upd_idx;
                        r_hist  <= i_updHist;
                        r_t     <= i_updTaken;
                        r_row_b <= r_bias[w_upd_idx];
                        for (int i = 0; i < HIST_LEN; i++)
                            r_row_w[i] <= r_wt[w_upd_idx][i];
                        r_upd_ready <= 1'b0;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_row_b <= sat_step(r_row_b, r_t);
                    // t*x_i is +1 exactly when the outcome matches the history bit.
                    for (int i = 0; i < HIST_LEN; i++)
                        r_row_w[i] <= sat_step(r_row_w[i], r_t == r_hist[i]);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_bias[r_idx] <= r_row_b;
                    for (int i = 0; i < HIST_LEN; i++)
                        r_wt[r_idx][i] <= r_row_w[i];
                    if (r_train_cnt != 16'hFFFF)
                        r_train_cnt <= r_train_cnt + 16'd1;
                    r_upd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_upd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_predValid     = r_pred_valid;
    assign o_predTaken     = r_pred_taken;
    assign o_predSum       = r_pred_sum;
    assign o_predHist      = r_pred_hist;
    assign o_updReady      = r_upd_ready;
    assign o_trainCnt_16   = r_train_cnt;
    assign o_mispredCnt_16 = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_branch_predictor
// Description : Directed self-checking bench for perceptron_branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_branch_predictor;

    logic               clk;
    logic               rst;
    logic               pred_valid;
    logic [31:0]        pred_pc;
    logic               pred_valid_o;
    logic               pred_taken_o;
    logic signed [12:0] pred_sum_o;
    logic [7:0]         pred_hist_o;
    logic               upd_valid;
    logic               upd_ready;
    logic [31:0]        upd_pc;
    logic [7:0]         upd_hist;
    logic signed [12:0] upd_sum;
    logic               upd_taken;
    logic               upd_mis;
    logic [15:0]        train_cnt;
    logic [15:0]        mis_cnt;

    // Narrow-weight instance (WEIGHT_W=4, SUM_W=9)
    logic               p4_pred_valid;
    logic [31:0]        p4_pred_pc;
    logic               p4_pred_valid_o;
    logic               p4_pred_taken_o;
    logic signed [8:0]  p4_pred_sum_o;
    logic [7:0]         p4_pred_hist_o;
    logic               p4_upd_valid;
    logic               p4_upd_ready;
    logic [15:0]        p4_train_cnt;
    logic [15:0]        p4_mis_cnt;

    int errors = 0;
    int checks = 0;

    perceptron_branch_predictor dut (
        .i_clk(clk), .i_rst(rst),
        .i_predValid(pred_valid), .i_predPc_32(pred_pc),
        .o_predValid(pred_valid_o), .o_predTaken(pred_taken_o),
        .o_predSum(pred_sum_o), .o_predHist(pred_hist_o),
        .i_updValid(upd_valid), .o_updReady(upd_ready),
        .i_updPc_32(upd_pc), .i_updHist(upd_hist), .i_updSum(upd_sum),
        .i_updTaken(upd_taken), .i_updMispredict(upd_mis),
        .o_trainCnt_16(train_cnt), .o_mispredCnt_16(mis_cnt)
    );

    perceptron_branch_predictor #(.WEIGHT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_predValid(p4_pred_valid), .i_predPc_32(p4_pred_pc),
        .o_predValid(p4_pred_valid_o), .o_predTaken(p4_pred_taken_o),
        .o_predSum(p4_pred_sum_o), .o_predHist(p4_pred_hist_o),
        .i_updValid(p4_upd_valid), .o_updReady(p4_upd_ready),
        .i_updPc_32(32'h200), .i_updHist(8'h00), .i_updSum(9'sd0),
        .i_updTaken(1'b0), .i_updMispredict(1'b1),
        .o_trainCnt_16(p4_train_cnt), .o_mispredCnt_16(p4_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic do_predict(input logic [31:0] pc);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = pc;
        @(negedge clk);
        pred_valid = 1'b0;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [7:0] hist,
                                input int sum, input logic taken, input logic mis);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_hist  = hist;
        upd_sum   = 13'(sum);
        upd_taken = taken;
        upd_mis   = mis;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (pred_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", pred_valid_o); end
        checks++; if (pred_sum_o !== 13'sd0 || pred_taken_o !== 1'b0 || pred_hist_o !== 8'h00) begin
            errors++; $display("FAIL reset_pred: sum=%0d taken=%0b hist=%h want 0/0/00", pred_sum_o, pred_taken_o, pred_hist_o); end
        checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", upd_ready); end
        checks++; if (train_cnt !== 16'd0 || mis_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: train=%0d mis=%0d want 0/0", train_cnt, mis_cnt); end
    endtask

    task automatic test_predict;
        do_predict(32'h100);
        checks++; if (pred_valid_o !== 1'b1 || int'(pred_sum_o) !== 0 || pred_taken_o !== 1'b1 || pred_hist_o !== 8'h00) begin
            errors++; $display("FAIL predict_zero: v=%0b sum=%0d taken=%0b hist=%h want 1/0/1/00",
                               pred_valid_o, pred_sum_o, pred_taken_o, pred_hist_o); end
        @(negedge clk);
        checks++; if (pred_valid_o !== 1'b0) begin errors++; $display("FAIL predict_pulse: got %0b want 0", pred_valid_o); end
        do_predict(32'h104);
        checks++; if (pred_hist_o !== 8'h01) begin errors++; $display("FAIL ghr_shift: hist=%h want 01", pred_hist_o); end
    endtask

    task automatic test_train_mispredict;
        @(negedge clk);
        drive_update(32'h100, 8'h00, 0, 1'b0, 1'b1);
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL train_busy1: ready=%0b want 0", upd_ready); end
        @(negedge clk);
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL train_busy2: ready=%0b want 0", upd_ready); end
        @(negedge clk);
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd1 || mis_cnt !== 16'd1) begin
            errors++; $display("FAIL train_done: ready=%0b train=%0d mis=%0d want 1/1/1", upd_ready, train_cnt, mis_cnt); end
        do_predict(32'h100);
        checks++; if (int'(pred_sum_o) !== -9 || pred_taken_o !== 1'b0 || pred_hist_o !== 8'h00) begin
            errors++; $display("FAIL trained_row: sum=%0d taken=%0b hist=%h want -9/0/00", pred_sum_o, pred_taken_o, pred_hist_o); end
    endtask

    task automatic test_threshold;
        @(negedge clk);
        drive_update(32'h100, 8'h00, 40, 1'b0, 1'b0);
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd1) begin
            errors++; $display("FAIL no_train_40: ready=%0b train=%0d want 1/1", upd_ready, train_cnt); end
        drive_update(32'h100, 8'h00, -30, 1'b0, 1'b0);
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd1) begin
            errors++; $display("FAIL no_train_m30: ready=%0b train=%0d want 1/1", upd_ready, train_cnt); end
        // |29| == THETA sits on the training side of the boundary.
        drive_update(32'h100, 8'h00, 29, 1'b0, 1'b0);
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL train_29: ready=%0b want 0", upd_ready); end
        repeat (2) @(negedge clk);
        checks++; if (train_cnt !== 16'd2 || mis_cnt !== 16'd1) begin
            errors++; $display("FAIL train_29_cnt: train=%0d mis=%0d want 2/1", train_cnt, mis_cnt); end
        do_predict(32'h100);
        checks++; if (int'(pred_sum_o) !== -18 || pred_hist_o !== 8'h00) begin
            errors++; $display("FAIL train_29_row: sum=%0d hist=%h want -18/00", pred_sum_o, pred_hist_o); end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = 32'h104;
        drive_update(32'h300, 8'hA5, 0, 1'b1, 1'b1);
        @(negedge clk);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        checks++; if (pred_hist_o !== 8'h00 || int'(pred_sum_o) !== 0 || pred_taken_o !== 1'b1) begin
            errors++; $display("FAIL same_cycle_pred: hist=%h sum=%0d taken=%0b want 00/0/1", pred_hist_o, pred_sum_o, pred_taken_o); end
        checks++; if (mis_cnt !== 16'd2) begin errors++; $display("FAIL same_cycle_mis: got %0d want 2", mis_cnt); end
        do_predict(32'h104);
        checks++; if (pred_hist_o !== 8'h4B) begin errors++; $display("FAIL ghr_repair: hist=%h want 4b", pred_hist_o); end
        @(negedge clk);
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd3) begin
            errors++; $display("FAIL same_cycle_train: ready=%0b train=%0d want 1/3", upd_ready, train_cnt); end
    endtask

    task automatic test_back_to_back_abort;
        @(negedge clk);
        drive_update(32'h400, 8'h00, 5, 1'b1, 1'b0);
        @(negedge clk);
        drive_update(32'h404, 8'h00, 0, 1'b1, 1'b1);
        checks++; if (upd_ready !== 1'b0 || mis_cnt !== 16'd2) begin
            errors++; $display("FAIL held_calc: ready=%0b mis=%0d want 0/2", upd_ready, mis_cnt); end
        @(negedge clk);
        checks++; if (upd_ready !== 1'b0 || mis_cnt !== 16'd2) begin
            errors++; $display("FAIL held_write: ready=%0b mis=%0d want 0/2", upd_ready, mis_cnt); end
        @(negedge clk);
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd4 || mis_cnt !== 16'd2) begin
            errors++; $display("FAIL first_done: ready=%0b train=%0d mis=%0d want 1/4/2", upd_ready, train_cnt, mis_cnt); end
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (upd_ready !== 1'b0 || mis_cnt !== 16'd3) begin
            errors++; $display("FAIL second_accept: ready=%0b mis=%0d want 0/3", upd_ready, mis_cnt); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (upd_ready !== 1'b1 || train_cnt !== 16'd0 || mis_cnt !== 16'd0) begin
            errors++; $display("FAIL abort_cnt: ready=%0b train=%0d mis=%0d want 1/0/0", upd_ready, train_cnt, mis_cnt); end
        do_predict(32'h404);
        checks++; if (int'(pred_sum_o) !== 0 || pred_hist_o !== 8'h00) begin
            errors++; $display("FAIL abort_row: sum=%0d hist=%h want 0/00", pred_sum_o, pred_hist_o); end
        do_predict(32'h400);
        checks++; if (int'(pred_sum_o) !== 0) begin errors++; $display("FAIL reset_row_a: sum=%0d want 0", pred_sum_o); end
    endtask

    task automatic test_saturation;
        for (int k = 1; k <= 10; k++) begin
            int n;
            @(negedge clk);
            p4_upd_valid = 1'b1;
            @(negedge clk);
            p4_upd_valid = 1'b0;
            n = 0;
            while (p4_upd_ready !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++; if (p4_upd_ready !== 1'b1) begin errors++; $display("FAIL sat_ready_timeout: k=%0d ready=%0b want 1", k, p4_upd_ready); end
            if (k == 6 || k == 10) begin
                @(negedge clk);
                p4_pred_valid = 1'b1;
                p4_pred_pc    = 32'h200;
                @(negedge clk);
                p4_pred_valid = 1'b0;
                checks++; if (int'(p4_pred_sum_o) !== ((k == 6) ? -54 : -63) || p4_pred_taken_o !== 1'b0) begin
                    errors++; $display("FAIL sat_sum: k=%0d sum=%0d taken=%0b want %0d/0",
                                       k, p4_pred_sum_o, p4_pred_taken_o, (k == 6) ? -54 : -63); end
            end
        end
        checks++; if (p4_train_cnt !== 16'd10 || p4_mis_cnt !== 16'd10) begin
            errors++; $display("FAIL sat_cnt: train=%0d mis=%0d want 10/10", p4_train_cnt, p4_mis_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_hist = '0; upd_sum = '0; upd_taken = 1'b0; upd_mis = 1'b0;
        p4_pred_valid = 1'b0; p4_pred_pc = '0; p4_upd_valid = 1'b0;
        test_reset;
        test_predict;
        test_train_mispredict;
        test_threshold;
        test_same_cycle;
        test_back_to_back_abort;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
